// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: address-register load
// codes, FSM state encoding, grant identity and the wait counter width.
package mem_access_ctrl_pkg;

  localparam logic [1:0] AR_HOLD = 2'b00;
  localparam logic [1:0] AR_PC   = 2'b01;
  localparam logic [1:0] AR_ALU  = 2'b11;

  localparam int CNT_W = 4;  // holds WAIT_STATES up to 15

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_AR = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

  // Address-register load code for a given requester.
  function automatic logic [1:0] ar_code(input grant_t g);
    return (g == GNT_DATA) ? AR_ALU : AR_PC;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, reset : clock, async active-high reset
//   req[1:0]   : bit0 = fetch, bit1 = data
//   grant_en   : commit the current grant (updates last_grant)
//   gnt[1:0]   : one-hot grant, combinational from req and last_grant
module rr_arb2
  import mem_access_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  grant_t last_grant;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // tie: serve whoever was not granted last
      2'b11:   gnt = (last_grant == GNT_DATA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to DATA so fetch wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= GNT_DATA;
    else if (grant_en && |req)
      last_grant <= gnt[1] ? GNT_DATA : GNT_FETCH;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences the shared address register and memory port
// between instruction fetch and data load/store.
//   clk, reset            : clock, async active-high reset
//   fetch_req, data_req   : level requests, held until their done pulse
//   data_we, data_wdata   : store flag / data, sampled at grant only
//   mem_rdata             : memory read data
//   ar_rec                : address-register load code (PC / ALU / hold)
//   mem_rd, mem_wr        : memory strobes during ACCESS
//   mem_wdata             : latched store data
//   rd_data               : captured read data
//   fetch_done, data_done : one-cycle completion pulses
//   busy                  : high outside IDLE
// All outputs decode from registered state; nothing is combinational from inputs.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        ar_rec,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              fetch_done,
  output logic              data_done,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WS_L = CNT_W'(WAIT_STATES);

  state_t             state, state_nxt;
  grant_t             grant_q;
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rd_q;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         gnt;
  logic               is_read;
  logic               last_access;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({data_req, fetch_req}),
    .grant_en (state == ST_IDLE),
    .gnt      (gnt)
  );

  // Fetches are always reads; data grants follow the latched we.
  assign is_read     = (grant_q == GNT_FETCH) || !we_q;
  assign last_access = (state == ST_ACCESS) && (cnt == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (|gnt) state_nxt = ST_LOAD_AR;
      ST_LOAD_AR: state_nxt = ST_ACCESS;
      ST_ACCESS:  if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      grant_q <= GNT_FETCH;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && |gnt) begin
        grant_q <= gnt[1] ? GNT_DATA : GNT_FETCH;
        if (gnt[1]) begin
          we_q    <= data_we;
          wdata_q <= data_wdata;
        end
      end
      if (state == ST_LOAD_AR)
        cnt <= WS_L;
      else if (state == ST_ACCESS && cnt != '0)
        cnt <= cnt - 1'b1;
      if (last_access && is_read)
        rd_q <= mem_rdata;
    end
  end

  assign ar_rec     = (state == ST_LOAD_AR) ? ar_code(grant_q) : AR_HOLD;
  assign mem_rd     = (state == ST_ACCESS) && is_read;
  assign mem_wr     = (state == ST_ACCESS) && !is_read;
  assign mem_wdata  = wdata_q;
  assign rd_data    = rd_q;
  assign fetch_done = (state == ST_DONE) && (grant_q == GNT_FETCH);
  assign data_done  = (state == ST_DONE) && (grant_q == GNT_DATA);
  assign busy       = (state != ST_IDLE);

endmodule
